regfile_scoreboard: RTL and testbench

- Parametrised successor to the single-cycle RISC-V register file, for the pipelined core.
- Provides 2 asynchronous read ports, 1 clocked write port, and optional write-to-read bypass.
- Adds a per-register pending-write scoreboard: decode marks a destination busy at issue, and writeback clears it.
- Decode uses the busy/hazard outputs to stall on RAW dependencies.

---
 rtl/regfile_scoreboard.sv | 124 ++++++++++++
 tb/tb_regfile_scoreboard.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one write port, optional
// write-to-read bypass and a per-register pending-write scoreboard.
// Optional writeback trace: define RF_TRACE_EN.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 2**ADDR_W,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rd1_data,
  output logic [DATA_W-1:0] rd2_data,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              hazard,
  output logic [ADDR_W:0]   busy_count
);

  logic [DATA_W-1:0] regs_r [DEPTH];
  logic [DEPTH-1:0]  busy_r;
  logic [ADDR_W:0]   busy_count_r;

  logic              wr_ok_s;
  logic              iss_ok_s;
  logic [DEPTH-1:0]  set_mask_s;
  logic [DEPTH-1:0]  clr_mask_s;
  logic [DEPTH-1:0]  busy_next_s;
  logic              set_new_s;
  logic              clr_real_s;
  logic [ADDR_W:0]   count_next_s;

  logic [ADDR_W-1:0] rs_addr_s [2];
  logic [DATA_W-1:0] rd_data_s [2];
  logic [1:0]        rs_busy_s;

  // An address is writable when it exists and is not the hardwired zero register.
  function automatic logic writable(input logic [ADDR_W-1:0] a);
    return (32'(a) < 32'(DEPTH)) && !(ZERO_REG && (a == {ADDR_W{1'b0}}));
  endfunction

  assign wr_ok_s      = we && writable(wr_addr);
  assign iss_ok_s     = issue_valid && writable(issue_rd);
  assign rs_addr_s[0] = rs1_addr;
  assign rs_addr_s[1] = rs2_addr;

  // Scoreboard next state: clear on writeback, then set on issue so set wins.
  always_comb begin
    set_mask_s = {DEPTH{1'b0}};
    clr_mask_s = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      set_mask_s[i] = iss_ok_s && (issue_rd == ADDR_W'(i));
      clr_mask_s[i] = wr_ok_s && (wr_addr == ADDR_W'(i));
    end
    busy_next_s = (busy_r & ~clr_mask_s) | set_mask_s;
    set_new_s   = |(set_mask_s & ~busy_r);
    clr_real_s  = |(clr_mask_s & busy_r & ~set_mask_s);
    count_next_s = busy_count_r + (ADDR_W+1)'(set_new_s) - (ADDR_W+1)'(clr_real_s);
  end

  // Register array and scoreboard state; reset discards any same-cycle write or issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
      busy_r       <= {DEPTH{1'b0}};
      busy_count_r <= {(ADDR_W+1){1'b0}};
    end else begin
      if (wr_ok_s) begin
        regs_r[wr_addr] <= wr_data;
      end
      busy_r       <= busy_next_s;
      busy_count_r <= count_next_s;
    end
  end

  // Read ports: a bypassed write also hides the busy bit unless re-issued this cycle.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data_s[p] = {DATA_W{1'b0}};
      rs_busy_s[p] = 1'b0;
      if (rst || !writable(rs_addr_s[p])) begin
        rd_data_s[p] = {DATA_W{1'b0}};
        rs_busy_s[p] = 1'b0;
      end else if (BYPASS && we && (wr_addr == rs_addr_s[p])) begin
        rd_data_s[p] = wr_data;
        rs_busy_s[p] = issue_valid && (issue_rd == rs_addr_s[p]) && busy_r[rs_addr_s[p]];
      end else begin
        rd_data_s[p] = regs_r[rs_addr_s[p]];
        rs_busy_s[p] = busy_r[rs_addr_s[p]];
      end
    end
  end

  assign rd1_data   = rd_data_s[0];
  assign rd2_data   = rd_data_s[1];
  assign rs1_busy   = rs_busy_s[0];
  assign rs2_busy   = rs_busy_s[1];
  assign hazard     = rs_busy_s[0] | rs_busy_s[1];
  assign busy_count = busy_count_r;

`ifdef RF_TRACE_EN
  // Writeback trace with a warning for writebacks that had no pending issue.
  always @(posedge clk) begin
    if (!rst && we) begin
      $display("%0t rf wb x%0d = %h busy_count=%0d", $time, wr_addr, wr_data, busy_count_r);
      if (wr_ok_s && !busy_r[wr_addr]) begin
        $display("%0t rf warning: writeback to non-busy x%0d", $time, wr_addr);
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized bench for regfile_scoreboard: two configurations driven in parallel
// and checked every cycle against a behavioural array model, plus directed literals.
module tb_regfile_scoreboard;

  localparam int DEP [2] = '{32, 24};
  localparam bit ZR  [2] = '{1'b1, 1'b0};
  localparam bit BYP [2] = '{1'b1, 1'b0};

  logic        clk, rst;
  logic [4:0]  rs1_addr, rs2_addr, wr_addr, issue_rd;
  logic        we, issue_valid;
  logic [31:0] wr_data;

  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic        rs1_busy_b, rs2_busy_b, hazard_b, rs1_busy_n, rs2_busy_n, hazard_n;
  logic [5:0]  cnt_b, cnt_n;

  logic [31:0] mem_m  [2][32];
  logic        busy_m [2][32];

  int n_vec = 0;
  int n_err = 0;

  regfile_scoreboard dut_b (
    .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd1_data(rd1_b), .rd2_data(rd2_b), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1_busy(rs1_busy_b),
    .rs2_busy(rs2_busy_b), .hazard(hazard_b), .busy_count(cnt_b)
  );

  regfile_scoreboard #(.DEPTH(24), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_n (
    .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd1_data(rd1_n), .rd2_data(rd2_n), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1_busy(rs1_busy_n),
    .rs2_busy(rs2_busy_n), .hazard(hazard_n), .busy_count(cnt_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit wrt(input int m, input logic [4:0] a);
    return (int'(a) < DEP[m]) && !(ZR[m] && a == 5'd0);
  endfunction

  function automatic logic [31:0] exp_rd(input int m, input logic [4:0] a);
    if (BYP[m] && we && wr_addr == a && wrt(m, a)) return wr_data;
    else if (wrt(m, a)) return mem_m[m][a];
    else return 32'd0;
  endfunction

  function automatic logic exp_bsy(input int m, input logic [4:0] a);
    if (!wrt(m, a)) return 1'b0;
    else if (BYP[m] && we && wr_addr == a && !(issue_valid && issue_rd == a)) return 1'b0;
    else return busy_m[m][a];
  endfunction

  // reference state: write lands, clear on writeback, later set on issue wins
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int m = 0; m < 2; m++)
        for (int i = 0; i < 32; i++) begin
          mem_m[m][i]  <= 32'd0;
          busy_m[m][i] <= 1'b0;
        end
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (we && wrt(m, wr_addr)) begin
          mem_m[m][wr_addr]  <= wr_data;
          busy_m[m][wr_addr] <= 1'b0;
        end
        if (issue_valid && wrt(m, issue_rd)) busy_m[m][issue_rd] <= 1'b1;
      end
    end
  end

  task automatic check_inst(input int m, input string tag, input logic [31:0] r1,
                            input logic [31:0] r2, input logic b1, input logic b2,
                            input logic hz, input logic [5:0] cnt);
    logic [31:0] e1, e2;
    logic eb1, eb2;
    int c;
    c = 0;
    if (rst) begin
      e1 = 32'd0; e2 = 32'd0; eb1 = 1'b0; eb2 = 1'b0;
    end else begin
      e1 = exp_rd(m, rs1_addr); e2 = exp_rd(m, rs2_addr);
      eb1 = exp_bsy(m, rs1_addr); eb2 = exp_bsy(m, rs2_addr);
      for (int i = 0; i < 32; i++) c += int'(busy_m[m][i]);
    end
    chk({tag, ".rd1"}, r1, e1);
    chk({tag, ".rd2"}, r2, e2);
    chk({tag, ".rs1_busy"}, 32'(b1), 32'(eb1));
    chk({tag, ".rs2_busy"}, 32'(b2), 32'(eb2));
    chk({tag, ".hazard"}, 32'(hz), 32'(eb1 | eb2));
    chk({tag, ".busy_count"}, 32'(cnt), 32'(c));
  endtask

  // every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    check_inst(0, "byp", rd1_b, rd2_b, rs1_busy_b, rs2_busy_b, hazard_b, cnt_b);
    check_inst(1, "nobyp", rd1_n, rd2_n, rs1_busy_n, rs2_busy_n, hazard_n, cnt_n);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic iv, input logic [4:0] ird, input logic [4:0] a1,
                       input logic [4:0] a2);
    we = w; wr_addr = wa; wr_data = wd; issue_valid = iv; issue_rd = ird;
    rs1_addr = a1; rs2_addr = a2;
  endtask

  task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, a1, a2);
  endtask

  initial begin
    rst = 1'b1;
    idle(5'd0, 5'd0);
    cyc(); cyc();
    rst = 1'b0;

    // zero register
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0, 5'd0); #1;
    chk("zero_rd1_same_cycle", rd1_b, 32'd0);
    cyc(); idle(5'd0, 5'd0); #1;
    chk("zero_rd1", rd1_b, 32'd0);
    chk("zero_busy", 32'(rs1_busy_b), 32'd0);
    chk("zero_count", 32'(cnt_b), 32'd0);

    // bypass vs no bypass
    drive(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 5'd3, 5'd0); cyc();
    drive(1'b1, 5'd3, 32'h22, 1'b0, 5'd0, 5'd3, 5'd0); #1;
    chk("bypass_on", rd1_b, 32'h22);
    chk("bypass_off_old", rd1_n, 32'h11);
    cyc(); idle(5'd3, 5'd0); #1;
    chk("bypass_off_next", rd1_n, 32'h22);

    // busy_count 1,2,3,2
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 5'd0, 5'd0); cyc();
    chk("count_1", 32'(cnt_b), 32'd1);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 5'd0, 5'd0); cyc();
    chk("count_2", 32'(cnt_b), 32'd2);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd0, 5'd0); cyc();
    chk("count_3", 32'(cnt_b), 32'd3);
    drive(1'b1, 5'd2, 32'd5, 1'b0, 5'd0, 5'd0, 5'd0); cyc();
    chk("count_wb", 32'(cnt_b), 32'd2);
    drive(1'b1, 5'd1, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0); cyc();
    drive(1'b1, 5'd3, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0); cyc();
    chk("count_drained", 32'(cnt_b), 32'd0);

    // RAW stall on x6
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 5'd0, 5'd0); cyc();
    idle(5'd0, 5'd6); #1;
    chk("raw_busy", 32'(rs2_busy_b), 32'd1);
    chk("raw_hazard", 32'(hazard_b), 32'd1);
    cyc();
    chk("raw_busy_hold", 32'(rs2_busy_b), 32'd1);
    drive(1'b1, 5'd6, 32'h40, 1'b0, 5'd0, 5'd0, 5'd6); #1;
    chk("raw_wb_bypass_busy", 32'(rs2_busy_b), 32'd0);
    chk("raw_wb_bypass_data", rd2_b, 32'h40);
    chk("raw_wb_nobyp_busy", 32'(rs2_busy_n), 32'd1);
    cyc(); idle(5'd0, 5'd6); #1;
    chk("raw_after_busy", 32'(rs2_busy_b), 32'd0);
    chk("raw_after_hazard", 32'(hazard_b), 32'd0);
    chk("raw_after_data", rd2_b, 32'h40);
    chk("raw_after_data_nobyp", rd2_n, 32'h40);

    // simultaneous issue and writeback on x8
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 5'd0, 5'd0); cyc();
    chk("sim_count_before", 32'(cnt_b), 32'd1);
    drive(1'b1, 5'd8, 32'h88, 1'b1, 5'd8, 5'd8, 5'd0); #1;
    chk("sim_busy_same_cycle", 32'(rs1_busy_b), 32'd1);
    cyc(); idle(5'd8, 5'd0); #1;
    chk("sim_count_after", 32'(cnt_b), 32'd1);
    chk("sim_busy_after", 32'(rs1_busy_b), 32'd1);
    chk("sim_data", rd1_b, 32'h88);

    // asynchronous reset mid-run
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 5'd5, 5'd5, 5'd0); cyc();
    idle(5'd5, 5'd0); #1;
    chk("pre_rst_data", rd1_b, 32'hDEAD_BEEF);
    chk("pre_rst_busy", 32'(rs1_busy_b), 32'd1);
    rst = 1'b1;
    drive(1'b1, 5'd5, 32'h123, 1'b1, 5'd5, 5'd5, 5'd0); #1;
    chk("rst_data", rd1_b, 32'd0);
    chk("rst_busy", 32'(rs1_busy_b), 32'd0);
    chk("rst_count", 32'(cnt_b), 32'd0);
    chk("rst_hazard", 32'(hazard_b), 32'd0);
    cyc();
    rst = 1'b0;
    idle(5'd5, 5'd0); #1;
    chk("post_rst_data", rd1_b, 32'd0);
    chk("post_rst_count", 32'(cnt_b), 32'd0);

    // randomized traffic, addresses biased toward a small window for collisions
    for (int n = 0; n < 3000; n++) begin
      cyc();
      rst         = ($urandom_range(0, 249) == 0);
      we          = ($urandom_range(0, 1) == 1);
      issue_valid = ($urandom_range(0, 9) < 4);
      wr_data     = $urandom;
      wr_addr     = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      issue_rd    = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      rs1_addr    = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      rs2_addr    = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
    end
    cyc();
    rst = 1'b0;
    idle(5'd0, 5'd0);
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
